// File: rtl/key_debounce_if.sv
`default_nettype none
// ============================================================================
// Module   : key_debounce_if
// Brief    : Key inputs and debounced event outputs of the key debounce array.
// Revision : 1.0
// ============================================================================
interface key_debounce_if #(
    parameter int N_KEYS = 4
);
    logic [N_KEYS-1:0] i_key_in;
    logic [N_KEYS-1:0] i_repeat_en;
    logic [N_KEYS-1:0] o_key_level;
    logic [N_KEYS-1:0] o_key_press;
    logic [N_KEYS-1:0] o_key_release;
    logic [N_KEYS-1:0] o_key_repeat;
    logic [N_KEYS-1:0] o_key_evt;
    logic              o_evt_lost;

    modport master (
        output i_key_in, i_repeat_en,
        input  o_key_level, o_key_press, o_key_release, o_key_repeat, o_key_evt, o_evt_lost
    );

    modport slave (
        input  i_key_in, i_repeat_en,
        output o_key_level, o_key_press, o_key_release, o_key_repeat, o_key_evt, o_evt_lost
    );
endinterface
`default_nettype wire

// File: rtl/key_debounce_array.sv
`default_nettype none
// ============================================================================
// Module   : key_debounce_array
// Brief    : N-channel key synchroniser/debouncer with press, release and
//            auto-repeat pulses plus optional one-hot event arbitration.
// Revision : 1.0
// ============================================================================
module key_debounce_array #(
    parameter int N_KEYS          = 4,
    parameter int CNT_W           = 27,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_DELAY    = 50000000,
    parameter int REPEAT_PERIOD   = 10000000,
    parameter int ACTIVE_LOW_IN   = 0,
    parameter int ONEHOT_EVT      = 0
) (
    input  wire logic          clk,
    input  wire logic          rst,
    key_debounce_if.slave      bus
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DELAY  = 2'd1,
        ST_REPEAT = 2'd2
    } rep_state_t;

    localparam logic [CNT_W-1:0]  c_DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  c_RD_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0]  c_RP_LAST = CNT_W'(REPEAT_PERIOD - 1);
    localparam logic [CNT_W-1:0]  c_CNT_ONE = CNT_W'(1);
    localparam logic [N_KEYS-1:0] c_KEY_ONE = N_KEYS'(1);

    logic [N_KEYS-1:0] w_key;
    logic [N_KEYS-1:0] r_s1;
    logic [N_KEYS-1:0] r_s2;
    logic [N_KEYS-1:0] r_level;
    logic [N_KEYS-1:0] r_press;
    logic [N_KEYS-1:0] r_release;
    logic [N_KEYS-1:0] r_repeat;
    logic [N_KEYS-1:0] r_evt;
    logic              r_lost;

    logic [N_KEYS-1:0] w_press;
    logic [N_KEYS-1:0] w_release;
    logic [N_KEYS-1:0] w_repeat;
    logic [N_KEYS-1:0] w_evt_raw;
    logic [N_KEYS-1:0] w_evt;
    logic              w_lost;

    assign w_key = (ACTIVE_LOW_IN != 0) ? ~bus.i_key_in : bus.i_key_in;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_s1      <= '0;
            r_s2      <= '0;
            r_level   <= '0;
            r_press   <= '0;
            r_release <= '0;
            r_repeat  <= '0;
            r_evt     <= '0;
            r_lost    <= 1'b0;
        end else begin
            r_s1      <= w_key;
            r_s2      <= r_s1;
            r_level   <= r_level ^ (w_press | w_release);
            r_press   <= w_press;
            r_release <= w_release;
            r_repeat  <= w_repeat;
            r_evt     <= w_evt;
            r_lost    <= w_lost;
        end
    end

    for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
        logic [CNT_W-1:0] r_db_cnt;
        logic [CNT_W-1:0] r_rep_cnt;
        rep_state_t       r_state;
        logic             w_diff;
        logic             w_accept;
        logic             w_due;

        // Level flips on the edge where the mismatch run would reach its target.
        assign w_diff       = r_s2[i] ^ r_level[i];
        assign w_accept     = w_diff && (r_db_cnt == c_DB_LAST);
        assign w_press[i]   = w_accept && !r_level[i];
        assign w_release[i] = w_accept && r_level[i];
        assign w_due        = ((r_state == ST_DELAY)  && (r_rep_cnt == c_RD_LAST)) ||
                              ((r_state == ST_REPEAT) && (r_rep_cnt == c_RP_LAST));
        assign w_repeat[i]  = w_due && bus.i_repeat_en[i] && !w_release[i];

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                r_db_cnt  <= '0;
                r_rep_cnt <= '0;
                r_state   <= ST_IDLE;
            end else begin
                if (!w_diff || w_accept) begin
                    r_db_cnt <= '0;
                end else begin
                    r_db_cnt <= r_db_cnt + c_CNT_ONE;
                end

                case (r_state)
                    ST_IDLE: begin
                        r_rep_cnt <= '0;
                        if (w_press[i] && bus.i_repeat_en[i]) begin
                            r_state <= ST_DELAY;
                        end
                    end
                    ST_DELAY, ST_REPEAT: begin
                        if (w_release[i] || !bus.i_repeat_en[i]) begin
                            r_state   <= ST_IDLE;
                            r_rep_cnt <= '0;
                        end else if (w_due) begin
                            r_state   <= ST_REPEAT;
                            r_rep_cnt <= '0;
                        end else begin
                            r_rep_cnt <= r_rep_cnt + c_CNT_ONE;
                        end
                    end
                    default: begin
                        r_state   <= ST_IDLE;
                        r_rep_cnt <= '0;
                    end
                endcase
            end
        end
    end

    assign w_evt_raw = w_press | w_repeat;

    if (ONEHOT_EVT != 0) begin : g_onehot
        // x & -x isolates the lowest set bit; x & (x-1) is nonzero when more remain.
        assign w_evt  = w_evt_raw & (~w_evt_raw + c_KEY_ONE);
        assign w_lost = |(w_evt_raw & (w_evt_raw - c_KEY_ONE));
    end else begin : g_plain
        assign w_evt  = w_evt_raw;
        assign w_lost = 1'b0;
    end

    assign bus.o_key_level   = r_level;
    assign bus.o_key_press   = r_press;
    assign bus.o_key_release = r_release;
    assign bus.o_key_repeat  = r_repeat;
    assign bus.o_key_evt     = r_evt;
    assign bus.o_evt_lost    = r_lost;

endmodule
`default_nettype wire

// File: doc/key_debounce_array.md
Name: key_debounce_array

Overview:
Parametrised N-channel push-button front end for the game boards. It replaces the fixed four-direction key debouncer. Each channel is synchronised and debounced independently, and produces a stable level plus press, release and auto-repeat pulses. An optional one-hot arbitration mode lets the game controller and snake logic receive at most one new direction event per cycle.

Parameters:
N_KEYS, 4, number of independent key channels
CNT_W, 27, width of per-channel debounce and repeat counters
DEBOUNCE_CYCLES, 1000000, consecutive stable cycles required to accept a level change (>=1, < 2^CNT_W)
REPEAT_DELAY, 50000000, cycles from press pulse to first repeat pulse (>=1)
REPEAT_PERIOD, 10000000, cycles between subsequent repeat pulses (>=1)
ACTIVE_LOW_IN, 0, 1 = raw key_in is low when pressed (inverted before synchroniser)
ONEHOT_EVT, 0, 1 = key_evt limited to the single lowest-index event per cycle

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-low reset
key_in  in  N_KEYS  raw asynchronous button inputs
repeat_en  in  N_KEYS  per-channel auto-repeat enable, sampled every cycle
key_level  out  N_KEYS  debounced pressed level (1 = pressed)
key_press  out  N_KEYS  1-cycle pulse on accepted press
key_release  out  N_KEYS  1-cycle pulse on accepted release
key_repeat  out  N_KEYS  1-cycle auto-repeat pulse
key_evt  out  N_KEYS  key_press|key_repeat, arbitrated when ONEHOT_EVT=1
evt_lost  out  1  1-cycle pulse when arbitration dropped at least one event

Behaviour:
- Reset (rst=0, async): synchronisers, counters and all outputs go to 0. key_level=0 regardless of the physical key state. Any pressed key is accepted as a new press after reset release plus the debounce time.
- Input path: optional inversion, then a 2-FF synchroniser per channel; s[i] is the second-stage output.
- Debounce, per channel: db_cnt increments on every edge where s[i]!=key_level[i] and clears to 0 on any edge where they are equal.
  - On the edge where db_cnt would reach DEBOUNCE_CYCLES: key_level[i] toggles, db_cnt clears, and key_press[i] (rising) or key_release[i] (falling) is high for exactly the following cycle.
  - Latency from a clean key_in step to key_level: 2 + DEBOUNCE_CYCLES edges.
  - A glitch shorter than DEBOUNCE_CYCLES sampled cycles produces no change and no pulse.
- Repeat FSM, per channel. States: IDLE, DELAY, REPEAT.
  - IDLE -> DELAY on the press pulse; rep_cnt=0.
  - DELAY: rep_cnt counts. At REPEAT_DELAY cycles after the press pulse, emit key_repeat, go to REPEAT, rep_cnt=0.
  - REPEAT: emit key_repeat every REPEAT_PERIOD cycles.
  - Return to IDLE on the release pulse or when repeat_en[i]=0. Dropping repeat_en mid-count aborts with no pulse. Re-asserting repeat_en while held does not restart repeat; it waits for the next press.
  - A release and a due repeat in the same cycle: release wins, no repeat pulse.
- key_press, key_release and key_repeat are never simultaneously high on one channel. A press and a repeat cannot coincide.
- Arbitration:
  - ONEHOT_EVT=0: key_evt = key_press|key_repeat, and evt_lost is always 0.
  - ONEHOT_EVT=1: key_evt carries only the lowest-index set bit of key_press|key_repeat. evt_lost pulses in that cycle if more than one bit was set. key_press, key_repeat and key_level themselves are never masked.
- All outputs are registered; there are no combinational paths from key_in or repeat_en.
- Counters saturate-free: they never exceed their compare value. CNT_W must hold max(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD); the bench checks this with an elaboration assertion.

Test Plan:
Simulation parameters for all scenarios: N_KEYS=4, DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3, CNT_W=8.
1. Clean press: key_in[0] 0->1 held 30 cycles, repeat_en=0 -> key_level[0] rises 6 edges after the step; key_press[0] one cycle; key_repeat never pulses. On release: key_release[0] one cycle, 6 edges after the step.
2. Bounce: key_in[1] toggles with 3-cycle high/low bursts for 40 cycles, then holds 1 -> exactly one key_press[1], issued 6 edges after the final rising step; no key_release.
3. Auto-repeat: repeat_en[2]=1, key 2 held 25 cycles after acceptance -> key_repeat[2] at +10, +13, +16, +19, +22 after key_press[2]. Release -> no further repeats, one key_release[2].
4. Abort: repeat_en[2] cleared at +8 after press -> no key_repeat ever, even after repeat_en is re-set while held.
5. Arbitration: ONEHOT_EVT=1, keys 1 and 3 stepped in the same cycle -> key_press=4'b1010, key_evt=4'b0010, evt_lost=1 for one cycle. With ONEHOT_EVT=0: key_evt=4'b1010, evt_lost=0.
6. Reset mid-operation: assert rst=0 while key 0 is in REPEAT -> all outputs 0 asynchronously. Release rst with key still held -> new key_press[0] 6 edges later; first repeat at +10 after that press.
